// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: controller states, timer register
// map and the fixed delay width of the down-counter.
package timer_pkg;

  localparam int DW = 24;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD2   = 3'd1,
    S_LD1   = 3'd2,
    S_LD0   = 3'd3,
    S_WAIT  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [1:0] TMR_B0   = 2'd0;
  localparam logic [1:0] TMR_B1   = 2'd1;
  localparam logic [1:0] TMR_B2   = 2'd2;
  localparam logic [1:0] TMR_STOP = 2'd3;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting just after the last
// winner and returns a one-hot winner plus a valid flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [LW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares the single 24-bit down-counter timer between NREQ requesters: arbitrates,
// writes the delay bytes over the timer bus, waits for expiry and pulses done.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = timer_pkg::DW,
  localparam int LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic             tmr_ce,
  output logic             tmr_wren,
  output logic [1:0]       tmr_addr,
  output logic [7:0]       tmr_wdata,
  input  logic             tmr_int,
  output state_t           state_dbg
);

  state_t          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic            busy_d, ce_d, wren_d;
  logic [1:0]      addr_d;
  logic [7:0]      wdata_d;

  logic [NREQ-1:0] arb_winner;
  logic            arb_valid;
  logic [LW-1:0]   win_idx;
  logic [DW-1:0]   delay_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .last   (last_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    win_idx   = '0;
    delay_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_winner[i]) begin
        win_idx   = LW'(i);
        delay_sel = delay[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    last_d  = last_q;
    grant_d = grant;
    done_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = S_LD2;
          dly_d   = delay_sel;
          grant_d = arb_winner;
          last_d  = win_idx;
        end
      end
      S_LD2: state_d = S_LD1;
      S_LD1: state_d = S_LD0;
      S_LD0: state_d = S_WAIT;
      S_WAIT: begin
        // Expiry wins over a simultaneous request drop.
        if (tmr_int) begin
          done_d  = grant;
          grant_d = '0;
          state_d = S_IDLE;
        end else if ((req & grant) == '0) begin
          grant_d = '0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ce_d    = 1'b0;
    wren_d  = 1'b0;
    addr_d  = TMR_B0;
    wdata_d = 8'h00;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_LD2: begin
        ce_d = 1'b1; wren_d = 1'b1; addr_d = TMR_B2; wdata_d = dly_d[23:16];
      end
      S_LD1: begin
        ce_d = 1'b1; wren_d = 1'b1; addr_d = TMR_B1; wdata_d = dly_d[15:8];
      end
      S_LD0: begin
        ce_d = 1'b1; wren_d = 1'b1; addr_d = TMR_B0; wdata_d = dly_d[7:0];
      end
      S_ABORT: begin
        ce_d = 1'b1; wren_d = 1'b1; addr_d = TMR_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      last_q    <= LW'(NREQ - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      tmr_ce    <= 1'b0;
      tmr_wren  <= 1'b0;
      tmr_addr  <= 2'd0;
      tmr_wdata <= 8'h00;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      last_q    <= last_d;
      grant     <= grant_d;
      done      <= done_d;
      busy      <= busy_d;
      tmr_ce    <= ce_d;
      tmr_wren  <= wren_d;
      tmr_addr  <= addr_d;
      tmr_wdata <= wdata_d;
    end
  end

  assign state_dbg = state_q;

endmodule
